// File: rtl/uart_cmd_pkg.sv
// Shared constants, state/opcode encodings and the ASCII digit decoder for
// the UART command decoder.
package uart_cmd_pkg;

  localparam logic [7:0] CH_R  = 8'h72;
  localparam logic [7:0] CH_L  = 8'h6C;
  localparam logic [7:0] CH_U  = 8'h75;
  localparam logic [7:0] CH_D  = 8'h64;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_B  = 8'h62;
  localparam logic [7:0] CH_Z  = 8'h5A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic {IDLE, WAIT_ARG} state_t;

  typedef enum logic [1:0] {OP_SET, OP_CLR, OP_BTN} op_t;

  typedef enum logic [1:0] {SW_NONE, SW_TOG, SW_SET, SW_CLR} sw_act_t;

  // Returns {valid, value}; lowercase 'a'..'f' accepted only when allow_hex is set.
  function automatic logic [4:0] decode_char(input logic [7:0] c, input logic allow_hex);
    decode_char = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      decode_char = {1'b1, c[3:0]};
    end else if (allow_hex && c >= 8'h61 && c <= 8'h66) begin
      decode_char = {1'b1, c[3:0] + 4'd9};
    end
  endfunction

endpackage

// File: rtl/btn_pulse_gen.sv
// Per-button pulse stretcher: a trigger (re)loads PULSE_LEN, output is high
// while the counter is non-zero.
module btn_pulse_gen #(
  parameter int unsigned PULSE_LEN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pulse
);

  localparam int unsigned CW = $clog2(PULSE_LEN + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (trig) begin
      r_cnt <= CW'(PULSE_LEN);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign pulse = (r_cnt != '0);

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder: single-byte button/switch commands plus two-byte
// set/clear/button-index commands with an inter-byte timeout.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned N_SW        = 3,
  parameter int unsigned PULSE_LEN   = 1,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic [N_BTN-1:0] btn,
  output logic [N_SW-1:0]  sw,
  output logic             cmd_ok,
  output logic             cmd_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  state_t           r_state, w_state_nxt;
  op_t              r_op, w_op_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic [N_SW-1:0]  r_sw, w_sw_nxt;
  logic             r_ok, r_err, w_ok, w_err;
  logic [N_BTN-1:0] w_trig;
  logic [4:0]       w_dig, w_hex;
  logic             w_bgo, w_bhit, w_shit;
  logic [3:0]       w_bidx, w_sidx;
  sw_act_t          w_sact;

  assign w_dig = decode_char(rx_data, 1'b0);
  assign w_hex = decode_char(rx_data, 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:
        if (rx_done && (rx_data == CH_S || rx_data == CH_C || rx_data == CH_B))
          w_state_nxt = WAIT_ARG;
      WAIT_ARG:
        if (rx_done || r_tmo == TMO_ONE) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Decode first into a (button index / switch action) request, then resolve
  // it against N_BTN / N_SW so out-of-range indices turn into errors.
  always_comb begin
    w_sw_nxt  = r_sw;
    w_op_nxt  = r_op;
    w_tmo_nxt = r_tmo;
    w_trig    = '0;
    w_ok      = 1'b0;
    w_err     = 1'b0;
    w_bgo     = 1'b0;
    w_bidx    = '0;
    w_sact    = SW_NONE;
    w_sidx    = '0;
    w_bhit    = 1'b0;
    w_shit    = 1'b0;

    case (r_state)
      IDLE:
        if (rx_done) begin
          case (rx_data)
            CH_R: begin w_bgo = 1'b1; w_bidx = 4'd0; end
            CH_L: begin w_bgo = 1'b1; w_bidx = 4'd1; end
            CH_U: begin w_bgo = 1'b1; w_bidx = 4'd2; end
            CH_D: begin w_bgo = 1'b1; w_bidx = 4'd3; end
            CH_Z: begin w_sw_nxt = '0; w_ok = 1'b1; end
            CH_CR, CH_LF, CH_SP: ;
            CH_S: begin w_op_nxt = OP_SET; w_tmo_nxt = TMO_LOAD; end
            CH_C: begin w_op_nxt = OP_CLR; w_tmo_nxt = TMO_LOAD; end
            CH_B: begin w_op_nxt = OP_BTN; w_tmo_nxt = TMO_LOAD; end
            default:
              if (w_dig[4]) begin
                w_sact = SW_TOG;
                w_sidx = w_dig[3:0];
              end else begin
                w_err = 1'b1;
              end
          endcase
        end
      WAIT_ARG:
        if (rx_done) begin
          case (r_op)
            OP_SET, OP_CLR:
              if (w_dig[4]) begin
                w_sact = (r_op == OP_SET) ? SW_SET : SW_CLR;
                w_sidx = w_dig[3:0];
              end else begin
                w_err = 1'b1;
              end
            OP_BTN:
              if (w_hex[4]) begin
                w_bgo  = 1'b1;
                w_bidx = w_hex[3:0];
              end else begin
                w_err = 1'b1;
              end
            default: w_err = 1'b1;
          endcase
        end else if (r_tmo == TMO_ONE) begin
          w_err     = 1'b1;
          w_tmo_nxt = '0;
        end else begin
          w_tmo_nxt = r_tmo - 1'b1;
        end
      default: ;
    endcase

    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (w_bgo && 4'(i) == w_bidx) begin
        w_trig[i] = 1'b1;
        w_bhit    = 1'b1;
      end
    end
    if (w_bgo) begin
      w_ok  = w_bhit;
      w_err = !w_bhit;
    end

    for (int unsigned i = 0; i < N_SW; i++) begin
      if (w_sact != SW_NONE && 4'(i) == w_sidx) begin
        w_shit = 1'b1;
        case (w_sact)
          SW_TOG:  w_sw_nxt[i] = ~r_sw[i];
          SW_SET:  w_sw_nxt[i] = 1'b1;
          SW_CLR:  w_sw_nxt[i] = 1'b0;
          default: ;
        endcase
      end
    end
    if (w_sact != SW_NONE) begin
      w_ok  = w_shit;
      w_err = !w_shit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op  <= OP_SET;
      r_tmo <= '0;
      r_sw  <= '0;
      r_ok  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_op  <= w_op_nxt;
      r_tmo <= w_tmo_nxt;
      r_sw  <= w_sw_nxt;
      r_ok  <= w_ok;
      r_err <= w_err;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_pulse_gen #(
      .PULSE_LEN(PULSE_LEN)
    ) u_pulse (
      .clk  (clk),
      .rst  (rst),
      .trig (w_trig[g]),
      .pulse(btn[g])
    );
  end

  assign sw      = r_sw;
  assign cmd_ok  = r_ok;
  assign cmd_err = r_err;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with N_BTN=4, N_SW=3, PULSE_LEN=3,
// TIMEOUT_CYC=20; inputs change and outputs are sampled on the falling edge.
module tb_uart_cmd_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [3:0] btn;
  logic [2:0] sw;
  logic       cmd_ok;
  logic       cmd_err;

  int n_cmp = 0;
  int n_mis = 0;

  uart_cmd_decoder #(
    .N_BTN      (4),
    .N_SW       (3),
    .PULSE_LEN  (3),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .btn    (btn),
    .sw     (sw),
    .cmd_ok (cmd_ok),
    .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_btn, input logic [2:0] e_sw,
                         input logic e_ok, input logic e_err);
    check({tag, ".btn"}, 32'(btn), 32'(e_btn));
    check({tag, ".sw"},  32'(sw),  32'(e_sw));
    check({tag, ".ok"},  32'(cmd_ok),  32'(e_ok));
    check({tag, ".err"}, 32'(cmd_err), 32'(e_err));
  endtask

  // Called on a falling edge; the byte is consumed on the next rising edge
  // and the task returns on the falling edge right after it.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    idle(3);
    chk_all("reset", 4'b0000, 3'b000, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);

    // Button pulse width and retrigger
    send("r");      chk_all("r_c1", 4'b0001, 3'b000, 1'b1, 1'b0);
    idle(1);        chk_all("r_c2", 4'b0001, 3'b000, 1'b0, 1'b0);
    idle(1);        check("r_c3", 32'(btn), 32'h1);
    idle(1);        check("r_end", 32'(btn), 32'h0);
    send("d");      chk_all("d", 4'b1000, 3'b000, 1'b1, 1'b0);
    idle(3);        check("d_end", 32'(btn), 32'h0);
    send("r");
    send("r");      check("retrig_c1", 32'(btn), 32'h1);
    idle(2);        check("retrig_c3", 32'(btn), 32'h1);
    idle(1);        check("retrig_end", 32'(btn), 32'h0);

    // Toggle switches, out-of-range digit, ignored/invalid bytes
    send("0");      chk_all("t0a", 4'b0000, 3'b001, 1'b1, 1'b0);
    send("0");      chk_all("t0b", 4'b0000, 3'b000, 1'b1, 1'b0);
    send("2");      chk_all("t2",  4'b0000, 3'b100, 1'b1, 1'b0);
    send("7");      chk_all("t7",  4'b0000, 3'b100, 1'b0, 1'b1);
    send(8'h20);    chk_all("space", 4'b0000, 3'b100, 1'b0, 1'b0);
    send(8'h0D);    chk_all("cr",  4'b0000, 3'b100, 1'b0, 1'b0);
    send("x");      chk_all("bad", 4'b0000, 3'b100, 1'b0, 1'b1);

    // Set / clear / zero
    send("S");      chk_all("S_pre", 4'b0000, 3'b100, 1'b0, 1'b0);
    send("1");      chk_all("S1",  4'b0000, 3'b110, 1'b1, 1'b0);
    send("C");      chk_all("C_pre", 4'b0000, 3'b110, 1'b0, 1'b0);
    send("2");      chk_all("C2",  4'b0000, 3'b010, 1'b1, 1'b0);
    send("S");
    send("1");      chk_all("S1_again", 4'b0000, 3'b010, 1'b1, 1'b0);
    send("C");
    send("9");      chk_all("C9", 4'b0000, 3'b010, 1'b0, 1'b1);
    send("Z");      chk_all("Z",   4'b0000, 3'b000, 1'b1, 1'b0);

    // Button-index commands
    send("b");
    send("3");      chk_all("b3", 4'b1000, 3'b000, 1'b1, 1'b0);
    idle(3);
    send("b");
    send("f");      chk_all("bf", 4'b0000, 3'b000, 1'b0, 1'b1);
    send("b");
    send(8'h0A);    chk_all("bLF", 4'b0000, 3'b000, 1'b0, 1'b1);
    send("r");      chk_all("after_bLF", 4'b0001, 3'b000, 1'b1, 1'b0);
    idle(3);

    // Timeout expiry, then argument arriving on the expiry cycle
    send("S");
    idle(19);       check("tmo_pre", 32'(cmd_err), 32'h0);
    idle(1);        chk_all("tmo", 4'b0000, 3'b000, 1'b0, 1'b1);
    idle(1);        check("tmo_once", 32'(cmd_err), 32'h0);
    idle(5);        check("tmo_quiet", 32'(cmd_err), 32'h0);
    send("S");
    idle(19);
    send("2");      chk_all("tmo_race", 4'b0000, 3'b100, 1'b1, 1'b0);
    idle(2);        check("tmo_race_quiet", 32'(cmd_err), 32'h0);

    // Reset in WAIT_ARG discards the opcode
    send("S");
    rst = 1'b0;
    idle(2);        chk_all("mid_rst", 4'b0000, 3'b000, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);        chk_all("post_rst", 4'b0000, 3'b000, 1'b0, 1'b0);
    send("1");      chk_all("post_rst_1", 4'b0000, 3'b010, 1'b1, 1'b0);
    send("1");      chk_all("post_rst_1b", 4'b0000, 3'b000, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
